// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with a 2-entry skid buffer and a registered upstream ready.
// Optional stall counter port enabled by defining PIPE_STALL_CNT_EN.
module pipe_skid_reg #(
   parameter int CTRL_W = 5,
   parameter int DATA_W = 203
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
`ifdef PIPE_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [CTRL_W-1:0] r_main_ctrl, w_main_ctrl_nxt;
   logic [DATA_W-1:0] r_main_data, w_main_data_nxt;
   logic [CTRL_W-1:0] r_skid_ctrl, w_skid_ctrl_nxt;
   logic [DATA_W-1:0] r_skid_data, w_skid_data_nxt;
   logic              r_out_valid;
   logic              r_in_ready;
   logic              w_accept;
   logic              w_emit;

   assign w_accept = in_valid & r_in_ready;
   assign w_emit   = r_out_valid & out_ready;

   always_comb begin
      // NOTE: every next value gets a default first so no path can infer a latch.
      w_state_nxt     = r_state;
      w_main_ctrl_nxt = r_main_ctrl;
      w_main_data_nxt = r_main_data;
      w_skid_ctrl_nxt = r_skid_ctrl;
      w_skid_data_nxt = r_skid_data;

      if (flush) begin
         // Main data is left as-is: it is don't-care once invalid and never X after reset.
         w_state_nxt     = S_EMPTY;
         w_main_ctrl_nxt = '0;
         w_skid_ctrl_nxt = '0;
         w_skid_data_nxt = '0;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt     = S_ONE;
                  w_main_ctrl_nxt = in_ctrl;
                  w_main_data_nxt = in_data;
               end
            end
            S_ONE: begin
               if (w_accept && w_emit) begin
                  w_main_ctrl_nxt = in_ctrl;
                  w_main_data_nxt = in_data;
               end else if (w_accept) begin
                  w_state_nxt     = S_TWO;
                  w_skid_ctrl_nxt = in_ctrl;
                  w_skid_data_nxt = in_data;
               end else if (w_emit) begin
                  w_state_nxt     = S_EMPTY;
                  w_main_ctrl_nxt = '0;
               end
            end
            S_TWO: begin
               // Skid beat is older than anything upstream, so it refills main first.
               if (w_emit) begin
                  w_state_nxt     = S_ONE;
                  w_main_ctrl_nxt = r_skid_ctrl;
                  w_main_data_nxt = r_skid_data;
                  w_skid_ctrl_nxt = '0;
                  w_skid_data_nxt = '0;
               end
            end
            default: begin
               w_state_nxt     = S_EMPTY;
               w_main_ctrl_nxt = '0;
               w_skid_ctrl_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_EMPTY;
         r_main_ctrl <= '0;
         r_main_data <= '0;
         r_skid_ctrl <= '0;
         r_skid_data <= '0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values of the others.
         r_state     <= w_state_nxt;
         r_main_ctrl <= w_main_ctrl_nxt;
         r_main_data <= w_main_data_nxt;
         r_skid_ctrl <= w_skid_ctrl_nxt;
         r_skid_data <= w_skid_data_nxt;
         r_out_valid <= (w_state_nxt != S_EMPTY);
         r_in_ready  <= (w_state_nxt != S_TWO);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_ctrl  = r_main_ctrl;
   assign out_data  = r_main_data;
   assign occupancy = r_state;

`ifdef PIPE_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   // Flush deliberately leaves the count alone; only reset clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (r_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule
